// File: rtl/clt_rng_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : clt_rng_pkg
//  Purpose  : Shared constants for the CLT Gaussian RNG: per-lane LFSR seeds,
//             reseed masks, tap placement and a constant-time clog2 helper.
//  Revision : 1.0 - initial release
// ============================================================================
package clt_rng_pkg;

    localparam int MAX_UNIF        = 8;
    localparam int SEED_W          = 31;
    // Fibonacci taps x^W + x^(W-3) + 1 (x^31 + x^28 + 1 for the default width)
    localparam int LFSR_TAP_OFFSET = 3;

    localparam logic [SEED_W-1:0] DEFAULT_SEED [MAX_UNIF] = '{
        31'h1ACE_B00C, 31'h2545_F491, 31'h3C6E_F372, 31'h5BD1_E995,
        31'h6A09_E667, 31'h0B67_AE85, 31'h510E_527F, 31'h1F83_D9AB
    };

    localparam logic [SEED_W-1:0] SEED_MASK [MAX_UNIF] = '{
        31'h0765_4321, 31'h1357_9BDF, 31'h2468_ACE0, 31'h3A5A_5A5A,
        31'h4C3C_3C3C, 31'h55AA_55AA, 31'h6F0F_0F0F, 31'h7123_4567
    };

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/clt_lfsr.sv
`default_nettype none
// ============================================================================
//  Module   : clt_lfsr
//  Purpose  : One Fibonacci LFSR lane with step, parallel load and an
//             all-zero guard on every load path; exposes its low bits.
//  Revision : 1.0 - initial release
// ============================================================================
module clt_lfsr
    import clt_rng_pkg::*;
#(
    parameter int               WIDTH    = 31,
    parameter int               OUT_BITS = 10,
    parameter logic [WIDTH-1:0] SEED     = 1
)(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_step,
    input  logic                i_load,
    input  logic [WIDTH-1:0]    i_load_val,
    output logic [OUT_BITS-1:0] o_bits
);

    // An all-zero state would lock the register forever, so it is replaced by 1.
    localparam logic [WIDTH-1:0] c_RESET_STATE = (SEED == '0) ? WIDTH'(1) : SEED;

    logic [WIDTH-1:0] r_state;
    logic [WIDTH-1:0] w_load_state;
    logic             w_feedback;

    assign w_load_state = (i_load_val == '0) ? WIDTH'(1) : i_load_val;
    assign w_feedback   = r_state[WIDTH-1] ^ r_state[WIDTH-1-LFSR_TAP_OFFSET];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_RESET_STATE;
        end else if (i_load) begin
            r_state <= w_load_state;
        end else if (i_step) begin
            r_state <= {r_state[WIDTH-2:0], w_feedback};
        end
    end

    assign o_bits = r_state[OUT_BITS-1:0];

endmodule
`default_nettype wire

// File: rtl/clt_gauss_rng_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : clt_gauss_rng_pipe
//  Purpose  : Central-limit Gaussian noise source. Sums NUM_UNIF signed LFSR
//             uniforms through a registered adder tree and streams one sample
//             per cycle on a valid/ready interface with full back-pressure.
//             Optional macro CLT_RNG_SEED_LOAD_EN adds seed_load/seed_in.
//  Revision : 1.0 - initial release
// ============================================================================
module clt_gauss_rng_pipe
    import clt_rng_pkg::*;
#(
    parameter int NUM_UNIF   = 4,
    parameter int UNIF_WIDTH = 10,
    parameter int LFSR_WIDTH = 31,
    parameter int OUT_WIDTH  = 12
)(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    output logic [OUT_WIDTH-1:0]  out,
    output logic                  out_valid,
    input  logic                  out_ready
`ifdef CLT_RNG_SEED_LOAD_EN
   ,input  logic                  seed_load,
    input  logic [LFSR_WIDTH-1:0] seed_in
`endif
);

    localparam int L     = clog2(NUM_UNIF);
    localparam int SUM_W = UNIF_WIDTH + L;
    localparam int NODES = 2 * NUM_UNIF - 1;

    logic                    w_stall;
    logic                    w_advance;
    logic                    w_load;
    logic [LFSR_WIDTH-1:0]   w_seed_base;
    logic [UNIF_WIDTH-1:0]   w_unif      [NUM_UNIF];
    // Heap-ordered tree: node 0 is the root, leaves sit at NUM_UNIF-1 .. NODES-1.
    logic signed [SUM_W-1:0] w_node_next [NODES];
    logic signed [SUM_W-1:0] r_node      [NODES];
    logic [L:0]              r_valid;

`ifdef CLT_RNG_SEED_LOAD_EN
    assign w_load      = seed_load;
    assign w_seed_base = seed_in;
`else
    assign w_load      = 1'b0;
    assign w_seed_base = '0;
`endif

    assign w_stall   = r_valid[L] & ~out_ready;
    assign w_advance = ~w_stall;

    generate
        for (genvar i = 0; i < NUM_UNIF; i++) begin : g_unif
            clt_lfsr #(
                .WIDTH    (LFSR_WIDTH),
                .OUT_BITS (UNIF_WIDTH),
                .SEED     (LFSR_WIDTH'(DEFAULT_SEED[i]))
            ) u_lfsr (
                .clk        (clk),
                .rst_n      (rst),
                .i_step     (w_advance & en),
                .i_load     (w_load),
                .i_load_val (w_seed_base ^ LFSR_WIDTH'(SEED_MASK[i])),
                .o_bits     (w_unif[i])
            );

            assign w_node_next[NUM_UNIF-1+i] = SUM_W'(signed'(w_unif[i]));
        end

        for (genvar s = 1; s <= L; s++) begin : g_stage
            localparam int c_FIRST = (NUM_UNIF >> s) - 1;
            for (genvar n = 0; n < (NUM_UNIF >> s); n++) begin : g_node
                assign w_node_next[c_FIRST+n] = r_node[2*(c_FIRST+n)+1]
                                              + r_node[2*(c_FIRST+n)+2];
            end
        end
    endgenerate

    // Seed load clears validity but leaves data alone; bubbles carry no meaning.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_node  <= '{default: '0};
            r_valid <= '0;
        end else begin
            if (w_load) begin
                r_valid <= '0;
            end else if (w_advance) begin
                r_valid <= {r_valid[L-1:0], en};
            end
            if (w_advance) begin
                r_node <= w_node_next;
            end
        end
    end

    assign out_valid = r_valid[L];

    generate
        if (OUT_WIDTH >= SUM_W) begin : g_out_ext
            assign out = OUT_WIDTH'(r_node[0]);
        end else begin : g_out_shift
            assign out = r_node[0][SUM_W-1 -: OUT_WIDTH];
        end
    endgenerate

endmodule
`default_nettype wire
